vram_arbiter: RTL and testbench

Shares the single asynchronous-SRAM VRAM port between the MPU bus and the display line-fetch engine inside `Core`. It accepts single-word MPU reads/writes and multi-word display read bursts, sequences them onto registered VRAM control/address/data lines, and returns read data one cycle after each access. Display is latency-critical and has priority, but a waiting MPU access is always served before the next display burst.

---
 rtl/vram_arb_pkg.sv | 18 +
 rtl/vram_burst_counter.sv | 41 ++++
 rtl/vram_arbiter.sv | 244 ++++++++++++++++++++++++
 tb/tb_vram_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vram_arb_pkg.sv
// vram_arb_pkg: shared definitions for the VRAM port arbiter.
//   arb_state_e          - arbiter FSM states (IDLE / MPU access / display burst)
//   LEN_WIDTH            - display burst length field width (0 encodes 2^LEN_WIDTH)
//   VRAM_ADDR_W_DEFAULT  - VRAM word-address width, also used by Core
//   VRAM_DATA_W_DEFAULT  - VRAM data width
package vram_arb_pkg;

  localparam int LEN_WIDTH           = 8;
  localparam int VRAM_ADDR_W_DEFAULT = 18;
  localparam int VRAM_DATA_W_DEFAULT = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MPU  = 2'd1,
    ST_DISP = 2'd2
  } arb_state_e;

endpackage

// File: rtl/vram_burst_counter.sv
// vram_burst_counter: address/length tracker for one display read burst.
//   load/load_addr/load_len - start a burst; the word at load_addr is issued
//                             in the same cycle by the arbiter, so the counter
//                             keeps the address of the *following* word
//   step                    - one more burst word issued
//   next_addr               - address of the next word (wraps at 2^AW)
//   last                    - the word currently on the VRAM bus is the final one
module vram_burst_counter #(
  parameter int AW = 18,
  parameter int LW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic          step,
  input  logic [AW-1:0] load_addr,
  input  logic [LW-1:0] load_len,
  output logic [AW-1:0] next_addr,
  output logic          last
);

  // Words still to go after the one on the bus. len-1 wraps 0 -> all ones,
  // which gives the 2^LW-word burst encoded by len == 0.
  logic [LW-1:0] rem;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      next_addr <= '0;
      rem       <= '0;
    end else if (load) begin
      next_addr <= load_addr + AW'(1);
      rem       <= load_len - LW'(1);
    end else if (step) begin
      next_addr <= next_addr + AW'(1);
      rem       <= rem - LW'(1);
    end
  end

  assign last = (rem == '0);

endmodule

// File: rtl/vram_arbiter.sv
// vram_arbiter: shares the single async-SRAM VRAM port between the MPU bus
// (single-word read/write) and the display line-fetch engine (read bursts).
//   clk, reset                 - clock, async active-high reset
//   mpu_req/wr/be/addr/wdata   - MPU access start pulse + sampled fields
//   mpu_busy/ack/rdata         - MPU status, completion pulse, read data
//   disp_req/addr/len          - display burst start pulse + sampled fields
//   disp_busy/valid/rdata/done - display status and returned burst words
//   vram_en/rd/wr/be/addr/data_out - registered VRAM bus (active high)
//   vram_data_in               - VRAM read data, captured at end of access
// Display has priority when both wait in IDLE; an MPU access that waited
// through a burst runs straight after that burst's last word.
module vram_arbiter #(
  parameter int VRAM_ADDR_WIDTH = vram_arb_pkg::VRAM_ADDR_W_DEFAULT,
  parameter int DATA_WIDTH      = vram_arb_pkg::VRAM_DATA_W_DEFAULT,
  parameter int LEN_WIDTH       = vram_arb_pkg::LEN_WIDTH
) (
  input  logic                       clk,
  input  logic                       reset,
  // MPU port
  input  logic                       mpu_req,
  input  logic                       mpu_wr,
  input  logic [1:0]                 mpu_be,
  input  logic [VRAM_ADDR_WIDTH-1:0] mpu_addr,
  input  logic [DATA_WIDTH-1:0]      mpu_wdata,
  output logic                       mpu_busy,
  output logic                       mpu_ack,
  output logic [DATA_WIDTH-1:0]      mpu_rdata,
  // display port
  input  logic                       disp_req,
  input  logic [VRAM_ADDR_WIDTH-1:0] disp_addr,
  input  logic [LEN_WIDTH-1:0]       disp_len,
  output logic                       disp_busy,
  output logic                       disp_valid,
  output logic [DATA_WIDTH-1:0]      disp_rdata,
  output logic                       disp_done,
  // VRAM bus
  output logic                       vram_en,
  output logic                       vram_rd,
  output logic                       vram_wr,
  output logic [1:0]                 vram_be,
  output logic [VRAM_ADDR_WIDTH-1:0] vram_addr,
  output logic [DATA_WIDTH-1:0]      vram_data_out,
  input  logic [DATA_WIDTH-1:0]      vram_data_in
);
  import vram_arb_pkg::*;

  localparam int AW = VRAM_ADDR_WIDTH;
  localparam int DW = DATA_WIDTH;
  localparam int LW = LEN_WIDTH;

  arb_state_e state, state_nxt;

  // pending = accepted but not yet started on the VRAM bus
  logic          mpu_pend, disp_pend;
  logic          mpu_wr_q;
  logic [1:0]    mpu_be_q;
  logic [AW-1:0] mpu_addr_q;
  logic [DW-1:0] mpu_wdata_q;
  logic [AW-1:0] disp_addr_q;
  logic [LW-1:0] disp_len_q;

  // A request pulse can start its access in the very next cycle, so the
  // FSM looks at the incoming pulse as well as the latched pending flag.
  logic mpu_take, disp_take, mpu_want, disp_want;
  assign mpu_take  = mpu_req  & ~mpu_busy;
  assign disp_take = disp_req & ~disp_busy;
  assign mpu_want  = mpu_pend  | mpu_take;
  assign disp_want = disp_pend | disp_take;

  logic          sel_wr;
  logic [1:0]    sel_be;
  logic [AW-1:0] sel_maddr, sel_daddr;
  logic [DW-1:0] sel_wdata;
  logic [LW-1:0] sel_len;
  assign sel_wr    = mpu_pend  ? mpu_wr_q    : mpu_wr;
  assign sel_be    = mpu_pend  ? mpu_be_q    : mpu_be;
  assign sel_maddr = mpu_pend  ? mpu_addr_q  : mpu_addr;
  assign sel_wdata = mpu_pend  ? mpu_wdata_q : mpu_wdata;
  assign sel_daddr = disp_pend ? disp_addr_q : disp_addr;
  assign sel_len   = disp_pend ? disp_len_q  : disp_len;

  // burst address / length tracking
  logic          burst_load, burst_step, burst_last;
  logic [AW-1:0] burst_addr;

  vram_burst_counter #(.AW(AW), .LW(LW)) u_burst (
    .clk       (clk),
    .reset     (reset),
    .load      (burst_load),
    .step      (burst_step),
    .load_addr (sel_daddr),
    .load_len  (sel_len),
    .next_addr (burst_addr),
    .last      (burst_last)
  );

  // next VRAM bus values, registered together with the state
  logic          en_n, rd_n, wr_n;
  logic [1:0]    be_n;
  logic [AW-1:0] addr_n;
  logic [DW-1:0] dout_n;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    burst_load = 1'b0;
    burst_step = 1'b0;
    en_n       = 1'b0;
    rd_n       = 1'b0;
    wr_n       = 1'b0;
    be_n       = 2'b00;
    addr_n     = vram_addr;
    dout_n     = vram_data_out;

    case (state)
      ST_IDLE: begin
        if (disp_want) begin
          state_nxt  = ST_DISP;
          burst_load = 1'b1;
        end else if (mpu_want) begin
          state_nxt  = ST_MPU;
        end
      end
      ST_MPU: begin
        if (disp_want) begin
          state_nxt  = ST_DISP;
          burst_load = 1'b1;
        end else begin
          state_nxt  = ST_IDLE;
        end
      end
      ST_DISP: begin
        // a waiting MPU access jumps ahead of any queued next burst
        if (!burst_last) begin
          burst_step = 1'b1;
        end else if (mpu_want) begin
          state_nxt  = ST_MPU;
        end else if (disp_want) begin
          burst_load = 1'b1;
        end else begin
          state_nxt  = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase

    case (state_nxt)
      ST_MPU: begin
        en_n   = 1'b1;
        rd_n   = ~sel_wr;
        wr_n   = sel_wr;
        be_n   = sel_be;
        addr_n = sel_maddr;
        dout_n = sel_wdata;
      end
      ST_DISP: begin
        en_n   = 1'b1;
        rd_n   = 1'b1;
        be_n   = 2'b11;
        addr_n = burst_load ? sel_daddr : burst_addr;
      end
      default: ;
    endcase
  end

  logic mpu_issue;
  assign mpu_issue = (state_nxt == ST_MPU);

  // ------------------------------------------------ request bookkeeping
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mpu_pend    <= 1'b0;
      disp_pend   <= 1'b0;
      mpu_busy    <= 1'b0;
      disp_busy   <= 1'b0;
      mpu_wr_q    <= 1'b0;
      mpu_be_q    <= 2'b00;
      mpu_addr_q  <= '0;
      mpu_wdata_q <= '0;
      disp_addr_q <= '0;
      disp_len_q  <= '0;
    end else begin
      mpu_pend  <= mpu_want  & ~mpu_issue;
      disp_pend <= disp_want & ~burst_load;
      // busy covers pending, the access, and the response cycle
      mpu_busy  <= mpu_take  | (mpu_busy  & ~mpu_ack);
      disp_busy <= disp_take | (disp_busy & ~disp_done);
      if (mpu_take) begin
        mpu_wr_q    <= mpu_wr;
        mpu_be_q    <= mpu_be;
        mpu_addr_q  <= mpu_addr;
        mpu_wdata_q <= mpu_wdata;
      end
      if (disp_take) begin
        disp_addr_q <= disp_addr;
        disp_len_q  <= disp_len;
      end
    end
  end

  // ------------------------------------------------------ VRAM bus regs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vram_en       <= 1'b0;
      vram_rd       <= 1'b0;
      vram_wr       <= 1'b0;
      vram_be       <= 2'b00;
      vram_addr     <= '0;
      vram_data_out <= '0;
    end else begin
      vram_en       <= en_n;
      vram_rd       <= rd_n;
      vram_wr       <= wr_n;
      vram_be       <= be_n;
      vram_addr     <= addr_n;
      vram_data_out <= dout_n;
    end
  end

  // ------------------------------------------------------ read return
  // state reflects the access on the bus this cycle; its data is
  // captured at the end of the cycle and presented in the next one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mpu_ack    <= 1'b0;
      mpu_rdata  <= '0;
      disp_valid <= 1'b0;
      disp_rdata <= '0;
      disp_done  <= 1'b0;
    end else begin
      mpu_ack    <= (state == ST_MPU);
      disp_valid <= (state == ST_DISP);
      disp_done  <= (state == ST_DISP) & burst_last;
      if (state == ST_MPU && vram_rd) mpu_rdata  <= vram_data_in;
      if (state == ST_DISP)           disp_rdata <= vram_data_in;
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: directed + randomized bench for vram_arbiter with an
// SRAM model on the VRAM bus, a reference memory and a scoreboard.
module tb_vram_arbiter;
  localparam int AW = 18;
  localparam int DW = 16;
  localparam int LW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          mpu_req = 1'b0, mpu_wr = 1'b0;
  logic [1:0]    mpu_be = 2'b00;
  logic [AW-1:0] mpu_addr = '0;
  logic [DW-1:0] mpu_wdata = '0;
  logic          mpu_busy, mpu_ack;
  logic [DW-1:0] mpu_rdata;
  logic          disp_req = 1'b0;
  logic [AW-1:0] disp_addr = '0;
  logic [LW-1:0] disp_len = '0;
  logic          disp_busy, disp_valid, disp_done;
  logic [DW-1:0] disp_rdata;
  logic          vram_en, vram_rd, vram_wr;
  logic [1:0]    vram_be;
  logic [AW-1:0] vram_addr;
  logic [DW-1:0] vram_data_out;
  logic [DW-1:0] vram_data_in = '0;

  vram_arbiter #(.VRAM_ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .clk(clk), .reset(reset),
    .mpu_req(mpu_req), .mpu_wr(mpu_wr), .mpu_be(mpu_be), .mpu_addr(mpu_addr),
    .mpu_wdata(mpu_wdata), .mpu_busy(mpu_busy), .mpu_ack(mpu_ack), .mpu_rdata(mpu_rdata),
    .disp_req(disp_req), .disp_addr(disp_addr), .disp_len(disp_len),
    .disp_busy(disp_busy), .disp_valid(disp_valid), .disp_rdata(disp_rdata), .disp_done(disp_done),
    .vram_en(vram_en), .vram_rd(vram_rd), .vram_wr(vram_wr), .vram_be(vram_be),
    .vram_addr(vram_addr), .vram_data_out(vram_data_out), .vram_data_in(vram_data_in)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string nm);
    total++;
    bad++;
    $display("FAIL %s (cycle %0d)", nm, cyc);
  endtask

  logic [75:0] all_out;
  assign all_out = {mpu_busy, mpu_ack, mpu_rdata, disp_busy, disp_valid, disp_rdata, disp_done,
                    vram_en, vram_rd, vram_wr, vram_be, vram_addr, vram_data_out};

  // background pattern of never-written VRAM words
  function automatic logic [15:0] pat(input logic [AW-1:0] a);
    logic [15:0] r;
    r = a[15:0] ^ {a[17:16], 14'h0} ^ 16'h5A3C;
    return r;
  endfunction

  // ---------------------------------------------------- SRAM on the bus
  logic [15:0] sram [int];

  always @(posedge clk) begin
    logic [15:0] w;
    if (vram_en && vram_wr) begin
      w = sram.exists(int'(vram_addr)) ? sram[int'(vram_addr)] : pat(vram_addr);
      if (vram_be[0]) w[7:0]  = vram_data_out[7:0];
      if (vram_be[1]) w[15:8] = vram_data_out[15:8];
      sram[int'(vram_addr)] = w;
    end
    #1;
    if (vram_en && vram_rd)
      vram_data_in = sram.exists(int'(vram_addr)) ? sram[int'(vram_addr)] : pat(vram_addr);
    else
      vram_data_in = '0;
  end

  // --------------------------------------------------- reference memory
  logic [15:0] ref_mem [int];

  function automatic logic [15:0] ref_rd(input logic [AW-1:0] a);
    return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : pat(a);
  endfunction

  typedef struct packed { logic rd; logic [15:0] data; int cyc; } mpu_exp_t;
  typedef struct packed { logic [15:0] data; logic last; int cyc; } disp_exp_t;
  mpu_exp_t  mq[$];
  disp_exp_t dq[$];

  // drivers: called at #1 after a rising edge; ecyc < 0 means "any cycle"
  task automatic issue_mpu(input logic wr, input logic [1:0] be, input logic [AW-1:0] a,
                           input logic [15:0] d, input int ecyc);
    mpu_exp_t e;
    logic [15:0] o;
    mpu_req = 1'b1; mpu_wr = wr; mpu_be = be; mpu_addr = a; mpu_wdata = d;
    e.rd = ~wr; e.cyc = ecyc; e.data = '0;
    if (wr) begin
      o = ref_rd(a);
      if (be[0]) o[7:0]  = d[7:0];
      if (be[1]) o[15:8] = d[15:8];
      ref_mem[int'(a)] = o;
    end else begin
      e.data = ref_rd(a);
    end
    mq.push_back(e);
  endtask

  task automatic issue_disp(input logic [AW-1:0] a, input logic [LW-1:0] len, input int ecyc);
    int n;
    logic [AW-1:0] x;
    disp_exp_t e;
    disp_req = 1'b1; disp_addr = a; disp_len = len;
    n = (len == '0) ? (1 << LW) : int'(len);
    x = a;
    for (int i = 0; i < n; i++) begin
      e.data = ref_rd(x);
      e.last = (i == n - 1);
      e.cyc  = (ecyc < 0) ? -1 : ecyc + 2 + i;
      dq.push_back(e);
      x = x + AW'(1);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
    mpu_req = 1'b0;
    disp_req = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((mq.size() != 0 || dq.size() != 0) && n < budget) begin
      @(posedge clk);
      n++;
    end
    if (n >= budget) begin
      fail_now("drain_timeout");
      mq.delete();
      dq.delete();
    end
    @(posedge clk); #1;
  endtask

  // ------------------------------------------------------------ monitor
  logic [15:0] hold_rdata = '0;
  mpu_exp_t  me;
  disp_exp_t de;

  always @(negedge clk) begin
    if (reset) begin
      hold_rdata = '0;
    end else begin
      if (mpu_ack) begin
        if (mq.size() == 0) fail_now("mpu_ack_unexpected");
        else begin
          me = mq.pop_front();
          if (me.rd) begin
            chk("mpu_rdata", mpu_rdata, me.data);
            hold_rdata = me.data;
          end else begin
            chk("mpu_rdata_on_write", mpu_rdata, hold_rdata);
          end
          if (me.cyc >= 0) chk("mpu_ack_cycle", cyc, me.cyc);
        end
      end
      if (disp_valid) begin
        if (dq.size() == 0) fail_now("disp_valid_unexpected");
        else begin
          de = dq.pop_front();
          chk("disp_rdata", disp_rdata, de.data);
          chk("disp_done", disp_done, de.last);
          if (de.cyc >= 0) chk("disp_valid_cycle", cyc, de.cyc);
        end
      end else if (disp_done) begin
        fail_now("disp_done_without_valid");
      end
    end
  end

  // ------------------------------------------------------------ stimulus
  initial begin
    int t;
    logic [AW-1:0] ea;
    sram[int'(18'h3FFFF)]    = 16'hBEEF;
    ref_mem[int'(18'h3FFFF)] = 16'hBEEF;
    #1 reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 chk("outputs_in_reset", all_out, '0);
    @(negedge clk); #2 reset = 1'b0;
    @(negedge clk);
    chk("reset_state", all_out, '0);
    @(posedge clk); #1;

    // MPU write while idle: one-cycle strobe, ack one cycle later
    t = cyc;
    issue_mpu(1'b1, 2'b01, 18'h00010, 16'h1234, t + 2);
    tick();
    @(negedge clk);
    chk("wr_bus", {vram_en, vram_rd, vram_wr, vram_be, vram_addr, vram_data_out},
        {1'b1, 1'b0, 1'b1, 2'b01, 18'h00010, 16'h1234});
    @(negedge clk);
    chk("wr_strobe_one_cycle", {vram_en, vram_wr}, 2'b00);
    wait_idle(20);

    // MPU read at the top address, busy window T+1..T+2
    t = cyc;
    issue_mpu(1'b0, 2'b11, 18'h3FFFF, 16'h0, t + 2);
    tick();
    @(negedge clk); chk("mpu_busy_t1", mpu_busy, 1'b1);
    @(negedge clk); chk("mpu_busy_t2", mpu_busy, 1'b1);
    @(negedge clk); chk("mpu_busy_t3", mpu_busy, 1'b0);
    @(posedge clk); #1;

    // burst across the address wrap
    t = cyc;
    issue_disp(18'h3FFFE, 8'd4, t);
    tick();
    ea = 18'h3FFFE;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("burst_addr", {vram_en, vram_rd, vram_be, vram_addr}, {1'b1, 1'b1, 2'b11, ea});
      ea = ea + AW'(1);
    end
    @(negedge clk); chk("disp_busy_last", disp_busy, 1'b1);
    @(negedge clk); chk("disp_busy_after", disp_busy, 1'b0);
    @(posedge clk); #1;

    // simultaneous requests: burst first, MPU right after its last access
    t = cyc;
    issue_disp(18'h00100, 8'd3, t);
    issue_mpu(1'b0, 2'b11, 18'h20005, 16'h0, t + 5);
    tick();
    repeat (3) @(negedge clk);
    @(negedge clk);
    chk("mpu_after_burst", {vram_en, vram_rd, vram_addr}, {1'b1, 1'b1, 18'h20005});
    wait_idle(20);

    // len 0 = 256 words; a mid-burst display pulse is dropped
    t = cyc;
    issue_disp(18'h01000, 8'd0, t);
    tick();
    repeat (100) @(posedge clk);
    #1;
    disp_req = 1'b1; disp_addr = 18'h05555; disp_len = 8'd5;
    tick();
    wait_idle(400);

    // reset in the middle of a len-8 burst, after 3 words returned
    t = cyc;
    issue_disp(18'h00200, 8'd8, t);
    tick();
    repeat (4) @(posedge clk);
    #2 reset = 1'b1;
    #1 chk("reset_mid_burst", all_out, '0);
    @(negedge clk);
    #2;
    dq.delete();
    reset = 1'b0;
    @(posedge clk); #1;
    t = cyc;
    issue_disp(18'h00300, 8'd3, t);
    tick();
    wait_idle(20);

    // randomized traffic, including pulses while busy
    for (int c = 0; c < 800; c++) begin
      if (mq.size() == 0) begin
        if ($urandom_range(2, 0) == 0)
          issue_mpu(1'($urandom_range(1, 0)), 2'($urandom_range(3, 0)),
                    18'h20000 + 18'($urandom_range(31, 0)), 16'($urandom), -1);
      end else if ($urandom_range(7, 0) == 0) begin
        mpu_req = 1'b1; mpu_wr = 1'b1; mpu_be = 2'b11;
        mpu_addr = 18'h20000 + 18'($urandom_range(31, 0)); mpu_wdata = 16'($urandom);
      end
      if (dq.size() == 0) begin
        if ($urandom_range(3, 0) == 0)
          issue_disp(18'($urandom_range(130560, 0)), 8'($urandom_range(16, 1)), -1);
      end else if ($urandom_range(9, 0) == 0) begin
        disp_req = 1'b1; disp_addr = 18'($urandom_range(130560, 0)); disp_len = 8'd7;
      end
      tick();
    end
    wait_idle(2000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog_timeout (cycle %0d)", cyc);
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
